// File: rtl/ask_modulator.sv
// ask_modulator: on-off keying modulator that turns a byte stream into a
// UART-framed amplitude sample stream (line 0 = carrier on, line 1 = carrier off).
// Frame: start(0), 8 data bits LSB first, optional even parity, stop(1).
// Optional feature macro: ASK_MODULATOR_PARITY_EN (adds the parity bit, 11-bit frames).
module ask_modulator #(
    parameter int WIDTH     = 16,
    parameter int SPB_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [7:0]           i_tdata,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    input  logic [WIDTH-1:0]     on_level,
    input  logic [WIDTH-1:0]     off_level,
    input  logic [SPB_WIDTH-1:0] samples_per_bit,
    output logic                 busy
);

    localparam logic [SPB_WIDTH-1:0] SPB_ONE  = {{(SPB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SPB_WIDTH-1:0] SPB_ZERO = {SPB_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef ASK_MODULATOR_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef ASK_MODULATOR_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t               state_q, state_d;
    logic [SPB_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           data_q, data_d;
    logic [WIDTH-1:0]     on_q, on_d;
    logic [WIDTH-1:0]     off_q, off_d;
    logic [SPB_WIDTH-1:0] spb_q, spb_d;

    logic                 hs_s;
    logic                 last_s;
    logic                 bit_end_s;
    logic                 accept_s;
    logic                 line_bit_s;
    logic [SPB_WIDTH-1:0] spb_eff_s;

    // Handshake / bit-boundary decode shared by the datapath and the FSM.
    always_comb begin
        hs_s      = enable & o_tready;
        last_s    = (cnt_q == (spb_q - SPB_ONE));
        bit_end_s = hs_s & last_s & (state_q != ST_IDLE);
        spb_eff_s = (samples_per_bit == SPB_ZERO) ? SPB_ONE : samples_per_bit;
        // Reset/clear blocks the handshake so an upstream byte is never lost.
        i_tready  = enable & ~reset & ~clear &
                    ((state_q == ST_IDLE) |
                     ((state_q == ST_STOP) & last_s & o_tready));
        accept_s  = i_tvalid & i_tready;
        o_tvalid  = enable;
        busy      = (state_q != ST_IDLE);
    end

    // Current line bit and the amplitude it maps to; idle uses the live off level.
    always_comb begin
        line_bit_s = 1'b1;
        case (state_q)
            ST_START:  line_bit_s = 1'b0;
            ST_DATA:   line_bit_s = data_q[bit_idx_q];
`ifdef ASK_MODULATOR_PARITY_EN
            ST_PARITY: line_bit_s = even_parity(data_q);
`endif
            ST_STOP:   line_bit_s = 1'b1;
            default:   line_bit_s = 1'b1;
        endcase
        if (state_q == ST_IDLE) begin
            o_tdata = off_level;
        end else if (line_bit_s) begin
            o_tdata = off_q;
        end else begin
            o_tdata = on_q;
        end
    end

    // Next-state, sample counter, bit index and frame-parameter latching.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        on_d      = on_q;
        off_d     = off_q;
        spb_d     = spb_q;
        if (reset | clear) begin
            state_d   = ST_IDLE;
            cnt_d     = SPB_ZERO;
            bit_idx_d = 3'd0;
        end else begin
            if (accept_s) begin
                data_d = i_tdata;
                on_d   = on_level;
                off_d  = off_level;
                spb_d  = spb_eff_s;
            end else begin
                data_d = data_q;
            end
            if (hs_s && (state_q != ST_IDLE)) begin
                cnt_d = last_s ? SPB_ZERO : (cnt_q + SPB_ONE);
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d   = ST_START;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s && (bit_idx_q == 3'd7)) begin
`ifdef ASK_MODULATOR_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bit_idx_d = 3'd0;
                    end else if (bit_end_s) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef ASK_MODULATOR_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        state_d = accept_s ? ST_START : ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = SPB_ZERO;
                    bit_idx_d = 3'd0;
                end
            endcase
        end
    end

    // State and datapath registers; reset is folded into the _d logic.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        bit_idx_q <= bit_idx_d;
        data_q    <= data_d;
        on_q      <= on_d;
        off_q     <= off_d;
        spb_q     <= (reset | clear) ? SPB_ONE : spb_d;
    end

endmodule
